// File: rtl/da_cache_reader.sv
// Read-side engine of the ping-pong RAM cache.
// Drains 2**AW-word banks towards the DA converter at one sample per DIV clocks.
module da_cache_reader #(
    parameter int AW   = 8,
    parameter int DW   = 32,
    parameter int DA_W = 8,
    parameter int DIV  = 4
) (
    input  logic            rdclock,
    input  logic            rst,
    input  logic            en,
    input  logic [1:0]      bank_ready,
    input  logic [DW-1:0]   q,
    output logic [AW:0]     rdaddress,
    output logic            rden,
    output logic [DA_W-1:0] da_data,
    output logic            da_valid,
    output logic [1:0]      bank_release,
    output logic            underrun,
    input  logic            clr_underrun
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, STARVE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            cur_bank;
    logic [AW-1:0]   word_addr;
    logic [CW-1:0]   div_cnt;
    logic            held;
    logic            rd_pend;
    logic [AW:0]     last_addr;
    logic [DA_W-1:0] hold;

    logic cur_ready;
    logic wa_zero;
    logic wa_last;
    logic rd_slot;
    logic starve;
    logic abort;
    logic enter;

    always_comb begin
        cur_ready = bank_ready[cur_bank];
        wa_zero   = (word_addr == '0);
        wa_last   = (word_addr == '1);
        rd_slot   = (state == PLAY) && (div_cnt == '0);
        // the ready level only matters at the start of a bank
        starve    = rd_slot && wa_zero && !cur_ready;
        rden      = rd_slot && !starve;
        abort     = (state != IDLE) && !en;
        state_nxt = state;
        enter     = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en && cur_ready) begin
                        state_nxt = PLAY;
                        enter     = 1'b1;
                    end
                end
                PLAY: begin
                    if (starve) state_nxt = STARVE;
                end
                STARVE: begin
                    if (cur_ready) begin
                        state_nxt = PLAY;
                        enter     = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rdaddress = rden ? {cur_bank, word_addr} : last_addr;
    assign da_valid  = rd_pend;
    assign da_data   = rd_pend ? q[DA_W-1:0] : hold;

    always_ff @(posedge rdclock or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge rdclock or posedge rst) begin
        if (rst) begin
            cur_bank     <= 1'b0;
            word_addr    <= '0;
            div_cnt      <= '0;
            held         <= 1'b0;
            rd_pend      <= 1'b0;
            last_addr    <= '0;
            hold         <= '0;
            bank_release <= 2'b00;
            underrun     <= 1'b0;
        end else begin
            rd_pend <= rden;
            if (rd_pend) hold <= q[DA_W-1:0];
            if (rden) last_addr <= {cur_bank, word_addr};
            // held guards against releasing a bank twice on abort
            if ((rden && wa_last) || (abort && held))
                bank_release <= cur_bank ? 2'b10 : 2'b01;
            else
                bank_release <= 2'b00;
            if (starve && en)      underrun <= 1'b1;
            else if (clr_underrun) underrun <= 1'b0;
            if (abort) begin
                cur_bank  <= 1'b0;
                word_addr <= '0;
                div_cnt   <= '0;
                held      <= 1'b0;
            end else begin
                if (enter) begin
                    div_cnt <= '0;
                    held    <= 1'b1;
                end else if (state == PLAY) begin
                    div_cnt <= (div_cnt == CW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
                end
                if (rden) begin
                    word_addr <= word_addr + 1'b1;
                    if (wa_last) begin
                        cur_bank <= ~cur_bank;
                        held     <= 1'b0;
                    end else if (wa_zero) begin
                        held <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
